// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: FIFO read port (rd_en/dout/empty) to valid/ready stream.
// Optional pop counter when FIFO_READER_STATS_EN is defined.
module fifo_stream_reader #(
  parameter int DWIDTH    = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] pop_count
`endif
);

  logic [1:0]        occ;
  logic [1:0]        occ_n;
  logic              inflight;
  logic              pop;
  logic [DWIDTH-1:0] head;
  logic [DWIDTH-1:0] tail;

  assign pop    = m_valid && m_ready;
  assign occ_n  = occ + {1'b0, inflight} - {1'b0, pop};
  assign m_data = head;

  // Issue a read only if its word is guaranteed a buffer slot.
  assign fifo_rd_en = !rst && !fifo_empty && (occ_n <= 2'd1);

  // Buffer occupancy, read tracking and head/tail data movement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= '0;
      inflight <= 1'b0;
      m_valid  <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ_n;
      m_valid  <= (occ_n != 2'd0);
      unique case (1'b1)
        inflight && (occ == 2'd0 || (occ == 2'd1 && pop)): begin
          head <= fifo_dout;
        end
        inflight && occ == 2'd2 && pop: begin
          head <= tail;
          tail <= fifo_dout;
        end
        inflight && occ == 2'd1 && !pop: begin
          tail <= fifo_dout;
        end
        !inflight && pop: begin
          head <= tail;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Count completed handshakes, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pop_count <= '0;
    else if (pop) pop_count <= pop_count + 1'b1;
  end
`endif

  // Buffered plus in-flight words can never exceed the two slots.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    ({1'b0, occ} + {2'b0, inflight}) <= 3'd2
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and randomised checks of fifo_stream_reader.
// A small FIFO model feeds the DUT; a log records every handshake.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef FIFO_READER_STATS_EN
  logic [CW-1:0] pop_count;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       force_empty = 1'b0;
  logic [7:0] rlog [0:1023];
  int         rcnt = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DWIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_READER_STATS_EN
    ,
    .pop_count  (pop_count)
`endif
  );

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  // FIFO model: one-cycle read latency.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr[9:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Log every accepted output word.
  always @(posedge clk) begin
    if (!rst && m_valid && m_ready) begin
      rlog[rcnt[9:0]] <= m_data;
      rcnt            <= rcnt + 1;
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[9:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_ready = 1'b1;
    push(8'h5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold: rd_en=%b valid=%b data=%h need 0 0 00",
                 fifo_rd_en, m_valid, m_data);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (fifo_rd_en !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_rd: got %b need 1", fifo_rd_en);
    end
    repeat (6) @(negedge clk);
    tests++;
    if (rcnt !== 1 || rlog[0] !== 8'h5A) begin
      fails++;
      $display("FAIL reset_first_word: cnt=%0d word=%h need 1 5a", rcnt, rlog[0]);
    end
  endtask

  task automatic test_single;
    logic ev;
    @(negedge clk);
    m_ready = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      ev = (i == 2);
      tests++;
      if (fifo_rd_en !== (i == 0) || m_valid !== ev ||
          (ev && m_data !== 8'hA5)) begin
        fails++;
        $display("FAIL single c%0d: rd_en=%b valid=%b data=%h need %b %b a5",
                 i, fifo_rd_en, m_valid, m_data, (i == 0), ev);
      end
    end
  endtask

  task automatic test_stream;
    logic ev;
    @(negedge clk);
    m_ready = 1'b1;
    for (int w = 1; w <= 8; w++) push(w[7:0]);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      ev = (i >= 2 && i < 10);
      tests++;
      if (fifo_rd_en !== (i < 8) || m_valid !== ev ||
          (ev && m_data !== 8'(i - 1))) begin
        fails++;
        $display("FAIL stream c%0d: rd_en=%b valid=%b data=%h need %b %b %h",
                 i, fifo_rd_en, m_valid, m_data, (i < 8), ev, 8'(i - 1));
      end
    end
  endtask

  task automatic test_backpressure;
    logic ev;
    int   base;
    @(negedge clk);
    m_ready = 1'b0;
    base = rcnt;
    for (int w = 0; w < 4; w++) push(8'h11 + 8'(w));
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      ev = (i >= 2);
      tests++;
      if (fifo_rd_en !== (i < 2) || m_valid !== ev ||
          (ev && m_data !== 8'h11)) begin
        fails++;
        $display("FAIL bp_hold c%0d: rd_en=%b valid=%b data=%h need %b %b 11",
                 i, fifo_rd_en, m_valid, m_data, (i < 2), ev);
      end
    end
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      ev = (i < 4);
      tests++;
      if (fifo_rd_en !== (i < 2) || m_valid !== ev ||
          (ev && m_data !== 8'h11 + 8'(i))) begin
        fails++;
        $display("FAIL bp_drain c%0d: rd_en=%b valid=%b data=%h need %b %b %h",
                 i, fifo_rd_en, m_valid, m_data, (i < 2), ev, 8'h11 + 8'(i));
      end
    end
    tests++;
    if (rcnt - base !== 4) begin
      fails++;
      $display("FAIL bp_count: got %0d need 4", rcnt - base);
    end
  endtask

  task automatic test_midreset;
    int base;
    @(negedge clk);
    m_ready = 1'b0;
    for (int w = 0; w < 6; w++) push(8'h21 + 8'(w));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL midrst_clear: valid=%b data=%h rd_en=%b need 0 00 0",
               m_valid, m_data, fifo_rd_en);
    end
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    base = rcnt;
    #1;
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_release: valid=%b need 0", m_valid);
    end
    repeat (12) @(negedge clk);
    tests++;
    if (rcnt - base !== 4) begin
      fails++;
      $display("FAIL midrst_count: got %0d need 4", rcnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rlog[base + i] !== 8'h23 + 8'(i)) begin
        fails++;
        $display("FAIL midrst_word%0d: got %h need %h",
                 i, rlog[base + i], 8'h23 + 8'(i));
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q [$];
    logic [7:0] v;
    int         k;
    int         base;
    int         cyc;
    k = 0;
    cyc = 0;
    base = rcnt;
    while ((k < 200 || (rcnt - base) < 200) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (k < 200 && $urandom_range(0, 2) != 0) begin
        v = 8'($urandom);
        push(v);
        exp_q.push_back(v);
        k++;
      end
      force_empty = ($urandom_range(0, 3) == 0);
      m_ready = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    force_empty = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (rcnt - base !== 200) begin
      fails++;
      $display("FAIL rand_count: got %0d need 200 (cycles %0d)", rcnt - base, cyc);
    end
    for (int i = 0; i < 200; i++) begin
      tests++;
      if (rlog[base + i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rand_word%0d: got %h need %h", i, rlog[base + i], exp_q[i]);
      end
    end
  endtask

`ifdef FIFO_READER_STATS_EN
  task automatic test_stats;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (pop_count !== 3'd0) begin
      fails++;
      $display("FAIL stats_reset: got %0d need 0", pop_count);
    end
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    for (int w = 0; w < 5; w++) push(8'h40 + 8'(w));
    repeat (10) @(negedge clk);
    tests++;
    if (pop_count !== 3'd5) begin
      fails++;
      $display("FAIL stats_five: got %0d need 5", pop_count);
    end
    for (int w = 0; w < 4; w++) push(8'h50 + 8'(w));
    repeat (10) @(negedge clk);
    tests++;
    if (pop_count !== 3'd1) begin
      fails++;
      $display("FAIL stats_wrap: got %0d need 1", pop_count);
    end
    for (int w = 0; w < 4; w++) push(8'h60 + 8'(w));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (pop_count !== 3'd0) begin
      fails++;
      $display("FAIL stats_midrst: got %0d need 0", pop_count);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_midreset();
    test_random();
`ifdef FIFO_READER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side adapter for the team's synchronous FIFO.
- Converts the FIFO's read-enable / registered-data / empty interface (one-cycle read latency) into a valid/ready stream.
- Sustains one word per cycle and applies lossless backpressure.
- Sits between a FIFO's read port and a downstream consumer, e.g. a fetch/decode stage or a UART transmit path.

Parameters:
- DWIDTH, 8, data word width; must match the attached FIFO's DWIDTH.
- CNT_WIDTH, 16, width of the pop counter (used only when the optional feature is compiled in).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- fifo_rd_en  output  1  read request to the FIFO.
- fifo_dout  input  DWIDTH  FIFO read data; valid the cycle after an accepted read.
- fifo_empty  input  1  FIFO empty flag.
- m_valid  output  1  output word valid.
- m_ready  input  1  consumer ready.
- m_data  output  DWIDTH  output word.
- pop_count  output  CNT_WIDTH  handshake counter; exists only with FIFO_READER_STATS_EN.

Behaviour:
- State:
  - 2-entry output buffer (head/tail), occupancy occ in {0,1,2}.
  - 1-bit inflight flag, set when a read was issued last cycle.
- Reset (async, rst=1):
  - occ=0, inflight=0, m_valid=0, m_data=0, pop_count=0.
  - fifo_rd_en forced 0 while rst=1, regardless of fifo_empty.
  - Reset mid-stream discards buffered and in-flight words; no partial output after release.
- Pop:
  - pop = m_valid && m_ready.
  - m_valid = (occ != 0), registered; no combinational path from m_ready to m_valid or m_data.
- Issue:
  - fifo_rd_en = !rst && !fifo_empty && (occ + inflight - pop) <= 1.
  - Combinational path m_ready -> fifo_rd_en is permitted.
- Inflight: inflight <= fifo_rd_en each cycle. The FIFO only honours reads when non-empty and issue is gated by !fifo_empty, so every issued read returns exactly one word.
- Capture: when inflight=1, fifo_dout is written into the buffer that cycle (at the tail, or directly as the new head if occ=0 or occ=1 with a simultaneous pop).
- Simultaneous capture and pop: occ unchanged; head advances to the next word.
- Invariant: occ + inflight <= 2 at every edge. Overflow of the buffer is a design error; assert it in simulation.
- Latency: a read issued in cycle t gives data on fifo_dout in t+1, captured at the end of t+1; m_valid rises in t+2 (2 cycles from the issue).
- Throughput: with m_ready=1 and the FIFO non-empty, fifo_rd_en stays high and m_valid stays high every cycle after the initial 2-cycle latency.
- Backpressure (m_ready=0): at most 2 further reads are issued, then fifo_rd_en=0 until a pop.
- Stability: m_data and m_valid hold while m_valid && !m_ready.
- Ordering: words leave m_data in FIFO order; no loss, no duplication.
- fifo_empty rising while inflight=1: the in-flight word is still captured.

Optional Feature:
- Macro: FIFO_READER_STATS_EN.
- Defined:
  - pop_count increments by 1 on each pop.
  - Wraps modulo 2^CNT_WIDTH.
  - Cleared by rst.
- Undefined: port pop_count and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst=1 with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0 throughout. Release -> first fifo_rd_en in the first cycle after release.
2. Single word: FIFO holds 0xA5, m_ready=1 -> fifo_rd_en high 1 cycle (t), m_valid high only in t+2 with m_data=0xA5, then m_valid=0.
3. Streaming: FIFO preloaded 0x01..0x08, m_ready=1 -> fifo_rd_en high 8 consecutive cycles; m_valid high 8 consecutive cycles carrying 0x01..0x08 in order.
4. Backpressure: FIFO holds 0x11..0x14, m_ready=0 -> exactly 2 fifo_rd_en pulses, m_valid=1 with m_data=0x11 stable. Raise m_ready -> 0x11..0x14 delivered with no gaps, no loss.
5. Random m_ready and fifo_empty toggling, 200 words -> output sequence equals input sequence; occ + inflight <= 2 assertion never fires.
6. Stats: FIFO_READER_STATS_EN defined, CNT_WIDTH=3 -> pop_count=5 after 5 pops; after 9 pops pop_count=1; rst mid-run -> pop_count=0.
